// File: rtl/instr_assembler_pkg.sv
// Shared CPU encoding constants: instruction formats, pack error codes,
// assembler FSM states and immediate sign-bit positions.
package instr_assembler_pkg;

  typedef enum logic [1:0] {
    FMT_I = 2'b00,
    FMT_S = 2'b01,
    FMT_B = 2'b10,
    FMT_J = 2'b11
  } fmt_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_RANGE    = 2'b01,
    ERR_MISALIGN = 2'b10
  } err_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FULL = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  // Bit index of the immediate sign bit for each format (decoder imm-select).
  localparam logic [4:0] IMM_MSB_I = 5'd11;
  localparam logic [4:0] IMM_MSB_S = 5'd11;
  localparam logic [4:0] IMM_MSB_B = 5'd12;
  localparam logic [4:0] IMM_MSB_J = 5'd20;

  typedef struct packed {
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } fields_t;

  function automatic logic [4:0] imm_msb(fmt_e f);
    case (f)
      FMT_I:   imm_msb = IMM_MSB_I;
      FMT_S:   imm_msb = IMM_MSB_S;
      FMT_B:   imm_msb = IMM_MSB_B;
      default: imm_msb = IMM_MSB_J;
    endcase
  endfunction

endpackage

// File: rtl/instr_assembler_if.sv
// Field-bundle handshake plus instruction-memory write port of the assembler.
interface instr_assembler_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  imm_sgn;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm;
  logic        last;
  logic        start;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [6:0]  count;
  logic        err;
  logic [1:0]  err_code;
  logic        done;

  modport master (
    output in_valid, imm_sgn, opcode, rd, funct3, rs1, rs2, imm, last, start,
    input  in_ready, wr_en, wr_addr, wr_data, count, err, err_code, done
  );

  modport slave (
    input  in_valid, imm_sgn, opcode, rd, funct3, rs1, rs2, imm, last, start,
    output in_ready, wr_en, wr_addr, wr_data, count, err, err_code, done
  );
endinterface

// File: rtl/instr_assembler_imm_pack.sv
// Combinational packer: places fields and immediate into an I/S/B/J word and
// flags out-of-range or misaligned immediates.
module imm_pack
  import instr_assembler_pkg::*;
(
  input  fmt_e        imm_sgn,
  input  logic [31:0] imm,
  input  fields_t     fields,
  output logic [31:0] instr,
  output err_e        err_code
);

  logic [31:0] imm_hi;
  logic        fits;
  logic        misalign;

  always_comb begin
    // Bits at and above the sign bit must be a pure sign extension.
    imm_hi   = $signed(imm) >>> imm_msb(imm_sgn);
    fits     = (imm_hi == '0) || (imm_hi == '1);
    misalign = ((imm_sgn == FMT_B) || (imm_sgn == FMT_J)) && imm[0];

    err_code = ERR_NONE;
    if (!fits)         err_code = ERR_RANGE;
    else if (misalign) err_code = ERR_MISALIGN;

    instr = '0;
    case (imm_sgn)
      FMT_I: instr = {imm[11:0], fields.rs1, fields.funct3, fields.rd, fields.opcode};
      FMT_S: instr = {imm[11:5], fields.rs2, fields.rs1, fields.funct3, imm[4:0],
                      fields.opcode};
      FMT_B: instr = {imm[12], imm[10:5], fields.rs2, fields.rs1, fields.funct3,
                      imm[4:1], imm[11], fields.opcode};
      default: instr = {imm[20], imm[10:1], imm[11], imm[19:12], fields.rd,
                        fields.opcode};
    endcase
  end

endmodule

// File: rtl/instr_assembler.sv
// Instruction assembler: accepts field bundles, writes encoded words to
// sequential instruction-memory addresses and tracks the first pack error.
module instr_assembler
  import instr_assembler_pkg::*;
#(
  parameter int          DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  instr_assembler_if.slave   bus
);

  state_e      state_q, state_d;
  logic [6:0]  count_q, count_d;
  logic        err_q, err_d;
  err_e        err_code_q, err_code_d;
  logic        wr_en_q, wr_en_d;
  logic [31:0] wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;

  fields_t     fields;
  logic [31:0] instr;
  err_e        pack_err;
  logic        ready;
  logic        accept;

  assign fields = '{opcode: bus.opcode, rd: bus.rd, funct3: bus.funct3,
                    rs1: bus.rs1, rs2: bus.rs2};

  imm_pack u_pack (
    .imm_sgn  (fmt_e'(bus.imm_sgn)),
    .imm      (bus.imm),
    .fields   (fields),
    .instr    (instr),
    .err_code (pack_err)
  );

  assign ready  = (state_q == ST_IDLE) || (state_q == ST_RUN);
  assign accept = bus.in_valid && ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= BASE_ADDR;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;

    if (accept) begin
      if (pack_err == ERR_NONE) begin
        wr_en_d   = 1'b1;
        wr_addr_d = BASE_ADDR + {23'b0, count_q, 2'b00};
        wr_data_d = instr;
        count_d   = count_q + 7'd1;
      end else begin
        err_d = 1'b1;
        if (err_code_q == ERR_NONE) err_code_d = pack_err;
      end
      // A rejected final bundle still terminates the program.
      if (bus.last)                  state_d = ST_DONE;
      else if (count_d == 7'(DEPTH)) state_d = ST_FULL;
      else                           state_d = ST_RUN;
    end else if (!ready && bus.start) begin
      state_d    = ST_IDLE;
      count_d    = '0;
      err_d      = 1'b0;
      err_code_d = ERR_NONE;
    end
  end

  assign bus.in_ready = ready;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.count    = count_q;
  assign bus.err      = err_q;
  assign bus.err_code = err_code_q;
  assign bus.done     = (state_q == ST_DONE);

endmodule

// File: doc/instr_assembler.md
INSTR_ASSEMBLER -- requirements
Module: instr_assembler

Interface
REQ-001 Parameter DEPTH, default 64: instruction-memory capacity in words.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000: byte address of the first written word.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  field bundle present.
REQ-006 in_ready  output  1  block accepts the bundle this cycle.
REQ-007 imm_sgn  input  2  format select: 00 I, 01 S, 10 B, 11 J.
REQ-008 opcode  input  7  goes to instr[6:0].
REQ-009 rd  input  5  goes to instr[11:7] (I, J).
REQ-010 funct3  input  3  goes to instr[14:12] (I, S, B).
REQ-011 rs1  input  5  goes to instr[19:15] (I, S, B).
REQ-012 rs2  input  5  goes to instr[24:20] (S, B).
REQ-013 imm  input  32  signed immediate value.
REQ-014 last  input  1  accepted bundle is the final word of the program.
REQ-015 start  input  1  re-arm after DONE or FULL.
REQ-016 wr_en  output  1  one-cycle write strobe to instruction memory.
REQ-017 wr_addr  output  32  byte address, BASE_ADDR + 4*index.
REQ-018 wr_data  output  32  encoded instruction word.
REQ-019 count  output  7  words written since the last rst or start.
REQ-020 err  output  1  sticky: at least one bundle was rejected.
REQ-021 err_code  output  2  first error: 01 range, 10 misaligned, 00 none.
REQ-022 done  output  1  high in the DONE state.

Function
REQ-023 Handshake: a bundle is accepted on a cycle where in_valid and in_ready are both 1; fields are sampled only on that cycle.
REQ-024 Latency: a bundle accepted in cycle N produces wr_en=1 with wr_data/wr_addr in cycle N+1; wr_en is 0 in every other cycle.
REQ-025 I encoding: instr[31:20]=imm[11:0]; valid range -2048..2047.
REQ-026 S encoding: instr[31:25]=imm[11:5], instr[11:7]=imm[4:0]; valid range -2048..2047.
REQ-027 B encoding: instr[31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11]; valid range -4096..4094; imm[0] must be 0.
REQ-028 J encoding: instr[31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12]; valid range -1048576..1048574; imm[0] must be 0.
REQ-029 Range check: imm[31:MSB] must all equal the field sign bit. Violation gives error 01; misalignment gives error 10; if both apply, 01 takes priority.
REQ-030 Rejected bundle: no wr_en, count unchanged, err set to 1, err_code latched only if it was 00. A rejected bundle with last=1 still moves to DONE.
REQ-031 FSM states IDLE, RUN, FULL, DONE. IDLE->RUN on the first accept. Any state->DONE after an accept with last=1. RUN->FULL when count reaches DEPTH without last.
REQ-032 in_ready is 1 in IDLE and RUN, and 0 in FULL and DONE.
REQ-033 start in FULL or DONE: next cycle state=IDLE, count=0, err=0, err_code=00. start is ignored in IDLE and RUN.
REQ-034 count increments in the same cycle wr_en is asserted; wr_addr uses the pre-increment count.
REQ-035 When the DEPTH-th word is written with last=1, the state goes to DONE, not FULL.

Reset
REQ-036 rst, when high at a clock edge, sets: state IDLE, wr_en 0, wr_addr BASE_ADDR, wr_data 0, count 0, err 0, err_code 00, done 0.
REQ-037 rst overrides start and any pending write. A write registered in the cycle rst is sampled is discarded (wr_en=0 next cycle).

Structure
REQ-038 The format codes (I/S/B/J), error codes and FSM state encodings go in the shared CPU package, alongside the immediate-select constants used by the decoder.
REQ-039 Packing and range checking go in one combinational sub-module, imm_pack, with ports imm_sgn, imm, fields -> instr, err_code. The top module holds the FSM, counter and output register.

Verification
REQ-040 I, imm=-1, opcode=0010011, rd=1, rs1=2, funct3=0 -> wr_data=32'hFFF1_0093, wr_addr=BASE_ADDR, count=1 the next cycle.
REQ-041 B, imm=-4, opcode=1100011, rs1=1, rs2=2, funct3=0 -> wr_data=32'hFE20_8EE3. Then B, imm=3 -> no wr_en, err=1, err_code=10.
REQ-042 S, imm=2048 -> rejected with err_code 01. A subsequent J, imm=5 (misaligned) -> err_code stays 01.
REQ-043 DEPTH=4: accept 4 words with last=0 -> FULL, in_ready=0. start -> IDLE, count=0, in_ready=1.
REQ-044 Assert rst in the cycle after an accept -> wr_en=0, count=0. Drive last=1 on the 2nd word -> done=1, in_ready=0, count=2.
